// File: rtl/mux_scan_hex_if.sv
// rtl/mux_scan_hex_if.sv - channel data, control and display bundle for mux_scan_hex
interface mux_scan_hex_if #(
  parameter int N_CH  = 4,
  parameter int W     = 4,
  parameter int SEL_W = $clog2(N_CH)
);
  logic [N_CH*W-1:0] data_in;
  logic [SEL_W-1:0]  sel;
  logic [1:0]        mode;
  logic [W-1:0]      mux_out;
  logic [SEL_W-1:0]  ch_idx;
  logic [7:0]        hex;
  logic              tick;

  modport master (
    output data_in, sel, mode,
    input  mux_out, ch_idx, hex, tick
  );

  modport slave (
    input  data_in, sel, mode,
    output mux_out, ch_idx, hex, tick
  );
endinterface

// File: rtl/mux_scan_hex.sv
// rtl/mux_scan_hex.sv - N-channel muxer with auto-scan, freeze and XOR modes driving a 7-seg digit
module mux_scan_hex #(
  parameter int N_CH  = 4,
  parameter int W     = 4,
  parameter int DWELL = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_scan_hex_if.slave  bus
);
  localparam int SEL_W = $clog2(N_CH);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_FREEZE = 2'b10,
    MODE_XOR    = 2'b11
  } mode_e;

  mode_e             mode;
  logic [W-1:0]      ch [N_CH];
  logic [W-1:0]      xor_all;
  logic [SEL_W-1:0]  sel_clamped;
  logic [SEL_W-1:0]  idx_next_wrap;
  logic [3:0]        nibble;

  logic [W-1:0]      mux_out_q, mux_out_d;
  logic [SEL_W-1:0]  ch_idx_q,  ch_idx_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [7:0]        hex_q,     hex_d;
  logic              tick_q,    tick_d;

  assign mode = mode_e'(bus.mode);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch[k] = bus.data_in[k*W +: W];
  end

  // Active-low gfedcba patterns for hex digits 0..F.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    xor_all = '0;
    for (int k = 0; k < N_CH; k++) begin
      xor_all = xor_all ^ ch[k];
    end
  end

  // Out-of-range selects (only possible when N_CH is not a power of two) pin to the last channel.
  always_comb begin
    sel_clamped = bus.sel;
    if ({1'b0, bus.sel} >= (SEL_W+1)'(N_CH)) begin
      sel_clamped = SEL_W'(N_CH - 1);
    end
  end

  always_comb begin
    idx_next_wrap = ch_idx_q + SEL_W'(1);
    if (ch_idx_q == SEL_W'(N_CH - 1)) begin
      idx_next_wrap = '0;
    end
  end

  always_comb begin
    mux_out_d = mux_out_q;
    ch_idx_d  = ch_idx_q;
    cnt_d     = '0;
    tick_d    = 1'b0;

    case (mode)
      MODE_MANUAL: begin
        ch_idx_d  = sel_clamped;
        mux_out_d = ch[sel_clamped];
      end
      MODE_SCAN: begin
        if (cnt_q == CNT_W'(DWELL - 1)) begin
          ch_idx_d = idx_next_wrap;
          tick_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        mux_out_d = ch[ch_idx_d];
      end
      MODE_XOR: begin
        mux_out_d = xor_all;
      end
      default: begin
        // FREEZE: everything shown holds.
      end
    endcase
  end

  always_comb begin
    nibble = '0;
    for (int b = 0; b < 4; b++) begin
      if (b < W) begin
        nibble[b] = mux_out_d[b];
      end
    end
  end

  always_comb begin
    hex_d = {1'b1, seg7(nibble)};
    if (mode == MODE_FREEZE) begin
      hex_d = {1'b0, hex_q[6:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mux_out_q <= '0;
      ch_idx_q  <= '0;
      cnt_q     <= '0;
      hex_q     <= 8'hC0;
      tick_q    <= 1'b0;
    end else begin
      mux_out_q <= mux_out_d;
      ch_idx_q  <= ch_idx_d;
      cnt_q     <= cnt_d;
      hex_q     <= hex_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.mux_out = mux_out_q;
  assign bus.ch_idx  = ch_idx_q;
  assign bus.hex     = hex_q;
  assign bus.tick    = tick_q;
endmodule

// File: tb/tb_mux_scan_hex.sv
// tb/tb_mux_scan_hex.sv - directed self-checking bench for mux_scan_hex
module tb_mux_scan_hex;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mux_scan_hex_if #(.N_CH(4), .W(4)) bus4 ();
  mux_scan_hex_if #(.N_CH(3), .W(4)) bus3 ();

  mux_scan_hex #(.N_CH(4), .W(4), .DWELL(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  mux_scan_hex #(.N_CH(3), .W(4), .DWELL(4)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] m, input logic [1:0] idx,
                           input logic [7:0] h, input logic t);
    check_eq({tag, ".mux"},  32'(bus4.mux_out), 32'(m));
    check_eq({tag, ".idx"},  32'(bus4.ch_idx),  32'(idx));
    check_eq({tag, ".hex"},  32'(bus4.hex),     32'(h));
    check_eq({tag, ".tick"}, 32'(bus4.tick),    32'(t));
  endtask

  logic [3:0] chv [4];
  logic [7:0] hexv [4];

  initial begin
    chv[0] = 4'hC; chv[1] = 4'hF; chv[2] = 4'h5; chv[3] = 4'hA;
    hexv[0] = 8'hC6; hexv[1] = 8'h8E; hexv[2] = 8'h92; hexv[3] = 8'h88;

    bus4.data_in = {4'hA, 4'h5, 4'hF, 4'hC};
    bus4.sel     = 2'd0;
    bus4.mode    = 2'b00;
    bus3.data_in = {4'h5, 4'hF, 4'hC};
    bus3.sel     = 2'd0;
    bus3.mode    = 2'b00;

    // Reset
    rst_n = 1'b0;
    step();
    step();
    check_out("reset", 4'h0, 2'd0, 8'hC0, 1'b0);
    check_eq("reset3.idx", 32'(bus3.ch_idx), 32'd0);
    rst_n = 1'b1;

    // MANUAL sweep
    for (int s = 0; s < 4; s++) begin
      bus4.sel = 2'(s);
      step();
      check_out($sformatf("manual%0d", s), chv[s], 2'(s), hexv[s], 1'b0);
    end

    // N_CH=3 clamp
    bus3.sel = 2'd3;
    step();
    check_eq("clamp3.idx", 32'(bus3.ch_idx), 32'd2);
    check_eq("clamp3.mux", 32'(bus3.mux_out), 32'h5);

    // SCAN from channel 0
    bus4.sel = 2'd0;
    step();
    bus4.mode = 2'b01;
    for (int s = 1; s <= 16; s++) begin
      step();
      check_out($sformatf("scan%0d", s), chv[(s/4)%4], 2'((s/4)%4), hexv[(s/4)%4], (s%4) == 0);
    end
    for (int s = 1; s <= 4; s++) step();
    check_out("scan_adv1", 4'hF, 2'd1, 8'h8E, 1'b1);

    // Live data while shown
    bus4.data_in = {4'hA, 4'h5, 4'h3, 4'hC};
    step();
    check_out("scan_live", 4'h3, 2'd1, 8'hB0, 1'b0);
    bus4.data_in = {4'hA, 4'h5, 4'hF, 4'hC};
    step();
    check_out("scan_cnt2", 4'hF, 2'd1, 8'h8E, 1'b0);

    // FREEZE mid-dwell
    bus4.mode = 2'b10;
    bus4.data_in = {4'h1, 4'h2, 4'h3, 4'h4};
    bus4.sel = 2'd3;
    step();
    check_out("freeze0", 4'hF, 2'd1, 8'h0E, 1'b0);
    bus4.data_in = {4'h7, 4'h7, 4'h7, 4'h7};
    bus4.sel = 2'd2;
    step();
    check_out("freeze1", 4'hF, 2'd1, 8'h0E, 1'b0);

    // Back to SCAN: full dwell before the next advance
    bus4.data_in = {4'hA, 4'h5, 4'hF, 4'hC};
    bus4.mode = 2'b01;
    for (int s = 1; s <= 3; s++) begin
      step();
      check_out($sformatf("rescan%0d", s), 4'hF, 2'd1, 8'h8E, 1'b0);
    end
    step();
    check_out("rescan4", 4'h5, 2'd2, 8'h92, 1'b1);

    // XOR: C^F^5^A = C, then 1^F^5^A = 1
    bus4.mode = 2'b11;
    step();
    check_out("xor0", 4'hC, 2'd2, 8'hC6, 1'b0);
    bus4.data_in = {4'hA, 4'h5, 4'hF, 4'h1};
    step();
    check_out("xor1", 4'h1, 2'd2, 8'hF9, 1'b0);
    bus4.data_in = {4'hA, 4'h5, 4'hF, 4'hC};

    // Reset mid-scan at idx 2, counter 3
    bus4.mode = 2'b01;
    for (int s = 1; s <= 3; s++) step();
    check_out("prerst", 4'h5, 2'd2, 8'h92, 1'b0);
    rst_n = 1'b0;
    step();
    check_out("midrst", 4'h0, 2'd0, 8'hC0, 1'b0);
    rst_n = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      step();
      check_out($sformatf("postrst%0d", s), 4'hC, 2'd0, 8'hC6, 1'b0);
    end
    step();
    check_out("postrst4", 4'hF, 2'd1, 8'h8E, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end
endmodule
